// File: rtl/commit_trace_sequencer.sv
// commit_trace_sequencer: captures up to NR_PORTS retiring instructions plus one
// exception record per cycle, numbers them in commit order, buffers them in a
// small FIFO and drains one record per cycle over a valid/ready trace port.
// Records that do not fit are dropped and counted; stall_o asks commit to hold
// off while fewer than NR_PORTS+1 slots remain free.
module commit_trace_sequencer #(
  parameter int NR_PORTS = 2,
  parameter int DEPTH    = 8,
  parameter int PC_W     = 64,
  parameter int DATA_W   = 64
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       enable_i,
  input  logic [NR_PORTS-1:0]        commit_valid_i,
  input  logic [NR_PORTS*PC_W-1:0]   commit_pc_i,
  input  logic [NR_PORTS*32-1:0]     commit_instr_i,
  input  logic [NR_PORTS*5-1:0]      commit_rd_i,
  input  logic [NR_PORTS-1:0]        commit_we_i,
  input  logic [NR_PORTS*DATA_W-1:0] commit_wdata_i,
  input  logic                       exc_valid_i,
  input  logic [PC_W-1:0]            exc_pc_i,
  input  logic [63:0]                exc_cause_i,
  input  logic [DATA_W-1:0]          exc_tval_i,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic                       trace_kind_o,
  output logic [15:0]                trace_seq_o,
  output logic [PC_W-1:0]            trace_pc_o,
  output logic [63:0]                trace_code_o,
  output logic [DATA_W-1:0]          trace_data_o,
  output logic [4:0]                 trace_rd_o,
  output logic                       trace_we_o,
  output logic                       stall_o,
  output logic [15:0]                drop_cnt_o
);

  // Candidate slots: one per commit port, then the exception record last.
  localparam int NC = NR_PORTS + 1;
  localparam int AW = $clog2(DEPTH);
  // Counts range 0..DEPTH, and DEPTH >= NC, so AW+1 bits cover every count here.
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] NC_C    = CW'(NC);

  typedef struct packed {
    logic              kind;
    logic [15:0]       seq;
    logic [PC_W-1:0]   pc;
    logic [63:0]       code;
    logic [DATA_W-1:0] data;
    logic [4:0]        rd;
    logic              we;
  } rec_t;

  rec_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_seq;
  logic [15:0]   r_drop;

  logic [NC-1:0] w_cand_v;
  rec_t          w_cand [NC];
  logic [CW-1:0] w_rank [NC];
  logic [CW-1:0] w_ncand;
  logic [CW-1:0] w_space;
  logic [CW-1:0] w_npush;
  logic [CW-1:0] w_ndrop;
  logic          w_pop;
  logic [16:0]   w_drop_sum;
  rec_t          w_head;

  // Per-port instruction candidates; the sequence number is the slot's rank
  // among this cycle's valid candidates added to the running counter.
  for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_port
    assign w_cand_v[gi] = enable_i & commit_valid_i[gi];
    assign w_cand[gi] = '{
      kind: 1'b0,
      seq:  r_seq + {{(16-CW){1'b0}}, w_rank[gi]},
      pc:   commit_pc_i[gi*PC_W +: PC_W],
      code: {32'b0, commit_instr_i[gi*32 +: 32]},
      data: commit_wdata_i[gi*DATA_W +: DATA_W],
      rd:   commit_rd_i[gi*5 +: 5],
      we:   commit_we_i[gi]
    };
  end

  assign w_cand_v[NR_PORTS] = enable_i & exc_valid_i;
  assign w_cand[NR_PORTS] = '{
    kind: 1'b1,
    seq:  r_seq + {{(16-CW){1'b0}}, w_rank[NR_PORTS]},
    pc:   exc_pc_i,
    code: exc_cause_i,
    data: exc_tval_i,
    rd:   5'd0,
    we:   1'b0
  };

  // Prefix count of valid candidates: rank gives each record its FIFO offset
  // and sequence offset, the final total is the number of candidates.
  always_comb begin
    w_ncand = '0;
    for (int c = 0; c < NC; c++) begin
      w_rank[c] = w_ncand;
      w_ncand   = w_ncand + CW'(w_cand_v[c]);
    end
  end

  // A slot freed by this cycle's pop is reusable by this cycle's pushes.
  assign w_pop      = (r_count != '0) & trace_ready_i;
  assign w_space    = DEPTH_C - r_count + CW'(w_pop);
  assign w_npush    = (w_ncand < w_space) ? w_ncand : w_space;
  assign w_ndrop    = w_ncand - w_npush;
  assign w_drop_sum = {1'b0, r_drop} + {{(17-CW){1'b0}}, w_ndrop};

  // Pointer, occupancy, sequence and drop-counter state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_seq   <= '0;
      r_drop  <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_npush);
      r_rptr  <= r_rptr + AW'(w_pop);
      r_count <= r_count + w_npush - CW'(w_pop);
      r_seq   <= r_seq + {{(16-CW){1'b0}}, w_npush};
      r_drop  <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  // Record storage (not reset): the leading candidates that fit are written
  // at consecutive slots starting from the write pointer.
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int c = 0; c < NC; c++) begin
        if (w_cand_v[c] && (w_rank[c] < w_space)) begin
          r_mem[r_wptr + AW'(w_rank[c])] <= w_cand[c];
        end
      end
    end
  end

  // Head fields come straight from storage, so they hold while the sink stalls.
  assign w_head        = r_mem[r_rptr];
  assign trace_valid_o = (r_count != '0);
  assign trace_kind_o  = w_head.kind;
  assign trace_seq_o   = w_head.seq;
  assign trace_pc_o    = w_head.pc;
  assign trace_code_o  = w_head.code;
  assign trace_data_o  = w_head.data;
  assign trace_rd_o    = w_head.rd;
  assign trace_we_o    = w_head.we;

  // Back-pressure from registered occupancy only.
  assign stall_o    = (DEPTH_C - r_count) < NC_C;
  assign drop_cnt_o = r_drop;

endmodule

// File: tb/tb_commit_trace_sequencer.sv
// Self-checking bench for commit_trace_sequencer: a table of hand-derived
// vectors, directed multi-cycle sequences, and randomized traffic checked
// every cycle against a queue-based reference model.
module tb_commit_trace_sequencer;

  localparam int NP     = 2;
  localparam int DEPTH  = 8;
  localparam int PC_W   = 64;
  localparam int DATA_W = 64;

  logic                     clk = 1'b0;
  logic                     rstn;
  logic                     enable_i;
  logic [NP-1:0]            commit_valid_i;
  logic [NP*PC_W-1:0]       commit_pc_i;
  logic [NP*32-1:0]         commit_instr_i;
  logic [NP*5-1:0]          commit_rd_i;
  logic [NP-1:0]            commit_we_i;
  logic [NP*DATA_W-1:0]     commit_wdata_i;
  logic                     exc_valid_i;
  logic [PC_W-1:0]          exc_pc_i;
  logic [63:0]              exc_cause_i;
  logic [DATA_W-1:0]        exc_tval_i;
  logic                     trace_valid_o;
  logic                     trace_ready_i;
  logic                     trace_kind_o;
  logic [15:0]              trace_seq_o;
  logic [PC_W-1:0]          trace_pc_o;
  logic [63:0]              trace_code_o;
  logic [DATA_W-1:0]        trace_data_o;
  logic [4:0]               trace_rd_o;
  logic                     trace_we_o;
  logic                     stall_o;
  logic [15:0]              drop_cnt_o;

  always #5 clk = ~clk;

  commit_trace_sequencer #(
    .NR_PORTS(NP), .DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rstn(rstn), .enable_i(enable_i),
    .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
    .commit_instr_i(commit_instr_i), .commit_rd_i(commit_rd_i),
    .commit_we_i(commit_we_i), .commit_wdata_i(commit_wdata_i),
    .exc_valid_i(exc_valid_i), .exc_pc_i(exc_pc_i),
    .exc_cause_i(exc_cause_i), .exc_tval_i(exc_tval_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_kind_o(trace_kind_o), .trace_seq_o(trace_seq_o),
    .trace_pc_o(trace_pc_o), .trace_code_o(trace_code_o),
    .trace_data_o(trace_data_o), .trace_rd_o(trace_rd_o),
    .trace_we_o(trace_we_o), .stall_o(stall_o), .drop_cnt_o(drop_cnt_o)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic        kind;
    logic [15:0] seq;
    logic [63:0] pc;
    logic [63:0] code;
    logic [63:0] data;
    logic [4:0]  rd;
    logic        we;
  } mrec_t;

  mrec_t       mq[$];
  int unsigned m_seq;
  int unsigned m_drop;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies the current inputs to the model as one clock edge.
  task automatic model_edge();
    mrec_t cands[$];
    mrec_t r;
    int    space;
    bit    pop;
    if (!rstn) begin
      mq.delete();
      m_seq  = 0;
      m_drop = 0;
      return;
    end
    pop = (mq.size() != 0) && trace_ready_i;
    if (enable_i) begin
      for (int p = 0; p < NP; p++) begin
        if (commit_valid_i[p]) begin
          r.kind = 1'b0;
          r.seq  = 16'd0;
          r.pc   = commit_pc_i[p*PC_W +: PC_W];
          r.code = {32'b0, commit_instr_i[p*32 +: 32]};
          r.data = commit_wdata_i[p*DATA_W +: DATA_W];
          r.rd   = commit_rd_i[p*5 +: 5];
          r.we   = commit_we_i[p];
          cands.push_back(r);
        end
      end
      if (exc_valid_i) begin
        r.kind = 1'b1;
        r.seq  = 16'd0;
        r.pc   = exc_pc_i;
        r.code = exc_cause_i;
        r.data = exc_tval_i;
        r.rd   = 5'd0;
        r.we   = 1'b0;
        cands.push_back(r);
      end
    end
    space = DEPTH - mq.size() + (pop ? 1 : 0);
    if (pop) void'(mq.pop_front());
    foreach (cands[i]) begin
      if (i < space) begin
        r     = cands[i];
        r.seq = 16'(m_seq);
        m_seq = (m_seq + 1) % 65536;
        mq.push_back(r);
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
  endtask

  task automatic check_outputs();
    chk("valid", 64'(trace_valid_o), 64'(mq.size() != 0));
    chk("stall", 64'(stall_o), 64'((DEPTH - mq.size()) < NP + 1));
    chk("drop",  64'(drop_cnt_o), 64'(m_drop));
    if (mq.size() != 0) begin
      chk("kind", 64'(trace_kind_o), 64'(mq[0].kind));
      chk("seq",  64'(trace_seq_o),  64'(mq[0].seq));
      chk("pc",   trace_pc_o,   mq[0].pc);
      chk("code", trace_code_o, mq[0].code);
      chk("data", trace_data_o, mq[0].data);
      chk("rd",   64'(trace_rd_o), 64'(mq[0].rd));
      chk("we",   64'(trace_we_o), 64'(mq[0].we));
    end
  endtask

  // One clock: model consumes the inputs, DUT sees the edge, outputs sampled 1ns later.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic rand_payload();
    commit_pc_i    = {$urandom, $urandom, $urandom, $urandom};
    commit_instr_i = {$urandom, $urandom};
    commit_rd_i    = 10'($urandom);
    commit_we_i    = 2'($urandom);
    commit_wdata_i = {$urandom, $urandom, $urandom, $urandom};
    exc_pc_i       = {$urandom, $urandom};
    exc_cause_i    = {$urandom, $urandom};
    exc_tval_i     = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cycle();
    cycle();
    rstn = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        en;
    logic [1:0]  cv;
    logic        exc;
    logic        rdy;
    logic        e_valid;
    logic        e_kind;
    logic [15:0] e_seq;
    logic        e_stall;
    logic [15:0] e_drop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic en, input logic [1:0] cv, input logic exc,
                              input logic rdy, input logic ev, input logic ek,
                              input int es, input logic est, input int ed);
    vec_t v;
    v.en = en; v.cv = cv; v.exc = exc; v.rdy = rdy;
    v.e_valid = ev; v.e_kind = ek; v.e_seq = 16'(es); v.e_stall = est; v.e_drop = 16'(ed);
    return v;
  endfunction

  initial begin
    rstn = 1'b0; enable_i = 1'b0; commit_valid_i = '0; exc_valid_i = 1'b0;
    trace_ready_i = 1'b0;
    rand_payload();

    // Table (applied straight after a reset): single push/pop, ordering with
    // exception, fill to full, overflow drops, full-with-pop, enable low, drain.
    tbl.push_back(mk(1, 2'b01, 0, 1, 1, 0,  0, 0, 0));
    tbl.push_back(mk(1, 2'b00, 0, 1, 0, 0,  0, 0, 0));
    tbl.push_back(mk(1, 2'b11, 1, 0, 1, 0,  1, 0, 0));
    tbl.push_back(mk(1, 2'b00, 0, 1, 1, 0,  2, 0, 0));
    tbl.push_back(mk(1, 2'b00, 0, 1, 1, 1,  3, 0, 0));
    tbl.push_back(mk(1, 2'b00, 0, 1, 0, 0,  0, 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 1, 0,  4, 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 1, 0,  4, 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 1, 0,  4, 1, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 1, 0,  4, 1, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 1, 0,  4, 1, 2));
    tbl.push_back(mk(1, 2'b11, 0, 1, 1, 0,  5, 1, 3));
    tbl.push_back(mk(0, 2'b11, 1, 1, 1, 0,  6, 1, 3));
    tbl.push_back(mk(1, 2'b00, 0, 1, 1, 0,  7, 1, 3));
    tbl.push_back(mk(1, 2'b00, 0, 1, 1, 0,  8, 0, 3));
    tbl.push_back(mk(1, 2'b00, 0, 1, 1, 0,  9, 0, 3));
    tbl.push_back(mk(1, 2'b00, 0, 1, 1, 0, 10, 0, 3));
    tbl.push_back(mk(1, 2'b00, 0, 1, 1, 0, 11, 0, 3));
    tbl.push_back(mk(1, 2'b00, 0, 1, 1, 0, 12, 0, 3));
    tbl.push_back(mk(1, 2'b00, 0, 1, 0, 0,  0, 0, 3));

    // Reset state.
    do_reset();
    $display("reset: valid=%0d stall=%0d drop=%0d", trace_valid_o, stall_o, drop_cnt_o);

    // Single push and drain with known payload.
    enable_i = 1'b1; commit_valid_i = 2'b01; exc_valid_i = 1'b0; trace_ready_i = 1'b1;
    commit_pc_i[63:0] = 64'h8000_0000; commit_instr_i[31:0] = 32'h0050_0093;
    commit_rd_i[4:0] = 5'd1; commit_we_i[0] = 1'b1; commit_wdata_i[63:0] = 64'd5;
    cycle();
    chk("single_valid", 64'(trace_valid_o), 64'd1);
    chk("single_kind",  64'(trace_kind_o),  64'd0);
    chk("single_seq",   64'(trace_seq_o),   64'd0);
    chk("single_pc",    trace_pc_o,         64'h8000_0000);
    chk("single_code",  trace_code_o,       64'h0050_0093);
    chk("single_data",  trace_data_o,       64'd5);
    $display("single push: seq=%0d code=0x%0h data=%0d", trace_seq_o, trace_code_o, trace_data_o);
    commit_valid_i = 2'b00;
    cycle();
    chk("single_drained", 64'(trace_valid_o), 64'd0);

    // Table-driven vectors.
    do_reset();
    foreach (tbl[i]) begin
      rand_payload();
      exc_cause_i    = 64'd2;
      enable_i       = tbl[i].en;
      commit_valid_i = tbl[i].cv;
      exc_valid_i    = tbl[i].exc;
      trace_ready_i  = tbl[i].rdy;
      cycle();
      chk($sformatf("tbl%0d_valid", i), 64'(trace_valid_o), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_stall", i), 64'(stall_o), 64'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_drop", i),  64'(drop_cnt_o), 64'(tbl[i].e_drop));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_seq", i),  64'(trace_seq_o),  64'(tbl[i].e_seq));
        chk($sformatf("tbl%0d_kind", i), 64'(trace_kind_o), 64'(tbl[i].e_kind));
        if (tbl[i].e_kind) begin
          chk($sformatf("tbl%0d_exc_rd", i), 64'(trace_rd_o), 64'd0);
          chk($sformatf("tbl%0d_exc_we", i), 64'(trace_we_o), 64'd0);
          chk($sformatf("tbl%0d_cause", i),  trace_code_o,    64'd2);
        end
      end
      $display("vec %0d: valid=%0d kind=%0d seq=%0d stall=%0d drop=%0d",
               i, trace_valid_o, trace_kind_o, trace_seq_o, stall_o, drop_cnt_o);
    end

    // Back-pressure hold: one entry (seq 13 after the table) held for 5 cycles.
    enable_i = 1'b1; commit_valid_i = 2'b01; exc_valid_i = 1'b0; trace_ready_i = 1'b0;
    commit_pc_i[63:0] = 64'h1234; commit_instr_i[31:0] = 32'hDEAD_BEEF;
    commit_rd_i[4:0] = 5'd7; commit_we_i[0] = 1'b1; commit_wdata_i[63:0] = 64'h55;
    cycle();
    enable_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_payload();
      commit_valid_i = 2'($urandom);
      cycle();
      chk("hold_valid", 64'(trace_valid_o), 64'd1);
      chk("hold_seq",   64'(trace_seq_o),   64'd13);
      chk("hold_pc",    trace_pc_o,         64'h1234);
      chk("hold_code",  trace_code_o,       64'hDEAD_BEEF);
      chk("hold_data",  trace_data_o,       64'h55);
      chk("hold_rd",    64'(trace_rd_o),    64'd7);
      chk("hold_we",    64'(trace_we_o),    64'd1);
      $display("hold %0d: seq=%0d pc=0x%0h", k, trace_seq_o, trace_pc_o);
    end
    trace_ready_i = 1'b1;
    cycle();
    chk("hold_drained", 64'(trace_valid_o), 64'd0);

    // Randomized traffic with varying sink readiness and occasional resets.
    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(10, 100);
      for (int k = 0; k < 200; k++) begin
        rand_payload();
        rstn           = ($urandom_range(0, 399) != 0);
        enable_i       = ($urandom_range(0, 7) != 0);
        commit_valid_i = 2'($urandom);
        exc_valid_i    = ($urandom_range(0, 3) == 0);
        trace_ready_i  = ($urandom_range(1, 100) <= rdy_pct);
        cycle();
      end
      $display("random block %0d: ready%%=%0d drop=%0d queued=%0d", blk, rdy_pct, drop_cnt_o, mq.size());
    end
    rstn = 1'b1;

    // Sequence wrap: stream 65535 records so the counter sits at 0xFFFF.
    do_reset();
    enable_i = 1'b1; exc_valid_i = 1'b0; trace_ready_i = 1'b1; commit_valid_i = 2'b01;
    for (int k = 0; k < 65535; k++) begin
      rand_payload();
      cycle();
    end
    $display("stream done: head seq=0x%0h", trace_seq_o);
    rand_payload();
    commit_valid_i = 2'b11; trace_ready_i = 1'b0;
    cycle();
    commit_valid_i = 2'b01;
    cycle();
    chk("wrap_head0", 64'(trace_seq_o), 64'hFFFE);
    commit_valid_i = 2'b00; trace_ready_i = 1'b1;
    cycle();
    chk("wrap_ffff", 64'(trace_seq_o), 64'hFFFF);
    cycle();
    chk("wrap_0000", 64'(trace_seq_o), 64'h0000);
    $display("wrap: head seq=0x%0h", trace_seq_o);
    commit_valid_i = 2'b11; trace_ready_i = 1'b0;
    cycle();

    // Reset with 4 buffered records.
    rstn = 1'b0;
    cycle();
    chk("rst_valid", 64'(trace_valid_o), 64'd0);
    chk("rst_drop",  64'(drop_cnt_o),    64'd0);
    chk("rst_stall", 64'(stall_o),       64'd0);
    rstn = 1'b1; commit_valid_i = 2'b01;
    cycle();
    chk("rst_first_valid", 64'(trace_valid_o), 64'd1);
    chk("rst_first_seq",   64'(trace_seq_o),   64'd0);
    $display("after reset: seq=%0d", trace_seq_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
